// File: rtl/readout_pkg.sv
// Shared types and defaults for the SD-readout scheduler.
// No logic of its own; latency and backpressure are set by the users of this package.
// Holds the FSM state encoding and the occupancy-counter width helper.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        REQ   = 3'd2,
        DRAIN = 3'd3,
        ERROR = 3'd4
    } readout_state_t;

    localparam int unsigned FIFO_DEPTH_WORDS = 512;
    localparam int unsigned BLOCK_WORDS      = 256;
    localparam int unsigned CHUNK_WORDS      = 128;

    // One extra code point so that a completely full FIFO is representable.
    function automatic int unsigned level_width(input int unsigned depth_words);
        return $clog2(depth_words + 1);
    endfunction

endpackage

// File: rtl/readout_level.sv
// FIFO occupancy up/down counter with overflow and underflow flags.
// Level updates one edge after the strobe; the flags are combinational on the strobes.
// No backpressure: an illegal strobe is flagged and the level holds instead of wrapping.
module readout_level
    import readout_pkg::*;
#(
    parameter int unsigned DepthWords = FIFO_DEPTH_WORDS,
    parameter int unsigned LevelW     = level_width(DepthWords)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic              rd,
    output logic [LevelW-1:0] level,
    output logic              ovf,
    output logic              udf
);

    localparam logic [LevelW-1:0] Full = LevelW'(DepthWords);

    // A simultaneous write and read cancel out, so they never fault even at the limits.
    assign ovf = wr && !rd && (level == Full);
    assign udf = rd && !wr && (level == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (clr) begin
            level <= '0;
        end else if (wr && !rd && !ovf) begin
            level <= level + LevelW'(1);
        end else if (rd && !wr && !udf) begin
            level <= level - LevelW'(1);
        end
    end

endmodule

// File: rtl/sd_readout_sched.sv
// Schedules SD block reads into the readout FIFO and gates STM chunk reads.
// sd_req asserts two edges after start; spi_d_ready is registered from the occupancy level.
// A block is requested only when a whole block fits, and a chunk opens only when a full chunk is buffered.
module sd_readout_sched
    import readout_pkg::*;
#(
    parameter int unsigned FifoDepthWords = FIFO_DEPTH_WORDS,
    parameter int unsigned BlockWords     = BLOCK_WORDS,
    parameter int unsigned ChunkWords     = CHUNK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] block_count,
    input  logic        stop,
    output logic        sd_req,
    input  logic        sd_done,
    input  logic        sd_err,
    input  logic        fifo_w,
    input  logic        fifo_r,
    output logic        fifo_flush,
    output logic        spi_d_ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned LevelW    = level_width(FifoDepthWords);
    localparam int unsigned ChunkCntW = $clog2(ChunkWords + 1);

    localparam logic [LevelW-1:0]    RoomMax   = LevelW'(FifoDepthWords - BlockWords);
    localparam logic [LevelW-1:0]    ChunkLvl  = LevelW'(ChunkWords);
    localparam logic [ChunkCntW-1:0] ChunkLast = ChunkCntW'(ChunkWords - 1);

    readout_state_t       state;
    readout_state_t       state_d;
    logic [LevelW-1:0]    level;
    logic                 ovf;
    logic                 udf;
    logic [15:0]          remaining;
    logic                 cont_mode;
    logic                 stop_pend;
    logic                 rdy_q;
    logic [ChunkCntW-1:0] chunk_cnt;
    logic                 flush_q;
    logic                 flush_d;
    logic                 kill_chunk;
    logic                 start_acc;
    logic                 stop_req;
    logic                 room;
    logic                 lvl_fault;

    readout_level #(
        .DepthWords (FifoDepthWords),
        .LevelW     (LevelW)
    ) u_level (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush_d),
        .wr    (fifo_w),
        .rd    (fifo_r),
        .level (level),
        .ovf   (ovf),
        .udf   (udf)
    );

    assign start_acc = start && ((state == IDLE) || (state == ERROR));
    assign stop_req  = stop || stop_pend;
    assign room      = (level <= RoomMax);
    // A read outside an open chunk means the STM lost sync with spi_d_ready.
    assign lvl_fault = ovf || udf || (fifo_r && !rdy_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (start) state_d = CHECK;
            end
            CHECK: begin
                if (stop_req)                               state_d = DRAIN;
                else if (!cont_mode && (remaining == '0))   state_d = DRAIN;
                else if (room)                              state_d = REQ;
            end
            REQ: begin
                // An SD block cannot be cut short, so a stop only takes effect at sd_done.
                if (sd_err)       state_d = ERROR;
                else if (sd_done) state_d = stop_req ? DRAIN : CHECK;
            end
            DRAIN: begin
                if (stop_req || ((level == '0) && !rdy_q)) state_d = IDLE;
            end
            ERROR: begin
                if (start) state_d = CHECK;
            end
            default: state_d = IDLE;
        endcase
        if (busy && lvl_fault) state_d = ERROR;
    end

    always_comb begin
        sd_req     = (state == REQ);
        busy       = (state == CHECK) || (state == REQ) || (state == DRAIN);
        err        = (state == ERROR);
        flush_d    = start_acc || ((state == DRAIN) && stop_req && !lvl_fault);
        kill_chunk = flush_d || (busy && stop) || (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            cont_mode <= 1'b0;
            stop_pend <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= flush_d;
            if (start_acc) begin
                remaining <= block_count;
                cont_mode <= (block_count == 16'd0);
                stop_pend <= 1'b0;
            end else begin
                if (state_d == IDLE)    stop_pend <= 1'b0;
                else if (busy && stop)  stop_pend <= 1'b1;
                if ((state == REQ) && sd_done && !sd_err && !cont_mode && (remaining != '0))
                    remaining <= remaining - 16'd1;
            end
        end
    end

    // Opening is gated on rdy_q being low at the sampling edge, which guarantees the
    // STM at least one low cycle between consecutive chunks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            chunk_cnt <= '0;
        end else if (kill_chunk) begin
            rdy_q <= 1'b0;
        end else if (rdy_q) begin
            if (fifo_r) begin
                chunk_cnt <= chunk_cnt + ChunkCntW'(1);
                if (chunk_cnt == ChunkLast) rdy_q <= 1'b0;
            end
        end else if (busy && !stop_pend && (level >= ChunkLvl)) begin
            rdy_q     <= 1'b1;
            chunk_cnt <= '0;
        end
    end

    assign spi_d_ready = rdy_q;
    assign fifo_flush  = flush_q;

endmodule

// File: tb/tb_sd_readout_sched.sv
// Directed bench for sd_readout_sched: finite run, backpressure, stop, errors, chunk gap, reset.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
// An SD writer and an STM reader model run cycle-by-cycle inside run_model.
module tb_sd_readout_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] block_count;
    logic        stop;
    logic        sd_req;
    logic        sd_done;
    logic        sd_err;
    logic        fifo_w;
    logic        fifo_r;
    logic        fifo_flush;
    logic        spi_d_ready;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    int sd_wr, stm_cnt, low_run, done_at, req_gap, cyc_idx;
    int n_done, n_rdy_rise, n_reads, n_writes, min_gap;
    bit prev_rdy, prev_req, fell, hit;

    always #5 clk = ~clk;

    sd_readout_sched dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .block_count (block_count),
        .stop        (stop),
        .sd_req      (sd_req),
        .sd_done     (sd_done),
        .sd_err      (sd_err),
        .fifo_w      (fifo_w),
        .fifo_r      (fifo_r),
        .fifo_flush  (fifo_flush),
        .spi_d_ready (spi_d_ready),
        .busy        (busy),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        sd_wr = 0; stm_cnt = 0; low_run = 0; done_at = -1; req_gap = -1; cyc_idx = 0;
        n_done = 0; n_rdy_rise = 0; n_reads = 0; n_writes = 0; min_gap = 1000;
        prev_rdy = spi_d_ready; prev_req = sd_req; fell = 1'b0;
    endtask

    // mode 0: until busy drops; 1: fixed budget; 2: until sd_req; 3: until 10 reads done
    task automatic run_model(input int budget, input bit sd_en, input bit stm_en, input int mode);
        hit = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!spi_d_ready && prev_rdy) fell = 1'b1;
            if (spi_d_ready && !prev_rdy) begin
                if (fell && (low_run < min_gap)) min_gap = low_run;
                n_rdy_rise++;
            end
            low_run = spi_d_ready ? 0 : low_run + 1;
            if (sd_req && !prev_req && (done_at >= 0) && (req_gap < 0)) req_gap = cyc_idx - done_at;
            prev_rdy = spi_d_ready;
            prev_req = sd_req;
            if ((mode == 0 && !busy) || (mode == 2 && sd_req) || (mode == 3 && n_reads >= 10)) begin
                hit = 1'b1;
                break;
            end
            fifo_w = 1'b0; fifo_r = 1'b0; sd_done = 1'b0;
            if (sd_en && sd_req) begin
                if (sd_wr < 256) begin
                    fifo_w = 1'b1; sd_wr++; n_writes++;
                end else begin
                    sd_done = 1'b1; sd_wr = 0; n_done++;
                    if (done_at < 0) done_at = cyc_idx;
                end
            end
            if (!spi_d_ready) stm_cnt = 0;
            else if (stm_en && stm_cnt < 128) begin
                fifo_r = 1'b1; stm_cnt++; n_reads++;
            end
            tick();
            cyc_idx++;
        end
        if (mode == 1) hit = 1'b1;
        fifo_w = 1'b0; fifo_r = 1'b0; sd_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; block_count = 16'd0; stop = 1'b0;
        sd_done = 1'b0; sd_err = 1'b0; fifo_w = 1'b0; fifo_r = 1'b0;
        #3;
        chk("rst_sd_req", 32'(sd_req), 0);
        chk("rst_ready", 32'(spi_d_ready), 0);
        chk("rst_flush", 32'(fifo_flush), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_level", 32'(dut.level), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // stop while idle has no effect
        stop = 1'b1; tick(); stop = 1'b0;
        chk("idle_stop_busy", 32'(busy), 0);
        chk("idle_stop_flush", 32'(fifo_flush), 0);

        // finite run of two blocks
        block_count = 16'd2; start = 1'b1; tick(); start = 1'b0;
        chk("start_flush", 32'(fifo_flush), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_req_e1", 32'(sd_req), 0);
        tick();
        chk("start_req_e2", 32'(sd_req), 1);
        chk("flush_one_cycle", 32'(fifo_flush), 0);
        reset_model();
        run_model(5000, 1'b1, 1'b1, 0);
        chk("fin_timeout", 32'(hit), 1);
        chk("fin_handshakes", 32'(n_done), 2);
        chk("fin_chunks", 32'(n_rdy_rise), 4);
        chk("fin_writes", 32'(n_writes), 512);
        chk("fin_reads", 32'(n_reads), 512);
        chk("fin_req_gap", 32'(req_gap), 2);
        chk("fin_level", 32'(dut.level), 0);
        chk("fin_busy", 32'(busy), 0);
        chk("fin_err", 32'(err), 0);

        // backpressure: continuous mode, STM never reads
        block_count = 16'd0; start = 1'b1; tick(); start = 1'b0;
        reset_model();
        run_model(700, 1'b1, 1'b0, 1);
        chk("bp_handshakes", 32'(n_done), 2);
        chk("bp_level", 32'(dut.level), 512);
        chk("bp_req_low", 32'(sd_req), 0);
        chk("bp_ready", 32'(spi_d_ready), 1);
        fifo_w = 1'b1; fifo_r = 1'b1; tick(); fifo_w = 1'b0; fifo_r = 1'b0;
        chk("pair_full_level", 32'(dut.level), 512);
        chk("pair_full_err", 32'(err), 0);
        chk("pair_full_busy", 32'(busy), 1);

        // STM drains back-to-back chunks until a third block fits
        reset_model();
        run_model(1000, 1'b0, 1'b1, 2);
        chk("bp_third_req", 32'(hit), 1);
        chk("bp_third_reads", 32'(n_reads), 257);
        chk("bp_third_level", 32'(dut.level), 255);
        chk("chunk_rises", 32'(n_rdy_rise), 2);
        chk("chunk_low_gap", 32'(min_gap), 1);

        // stop during REQ: block completes, then flush and idle
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_req_held", 32'(sd_req), 1);
        chk("stop_chunk_closed", 32'(spi_d_ready), 0);
        repeat (3) tick();
        chk("stop_req_still", 32'(sd_req), 1);
        sd_done = 1'b1; tick(); sd_done = 1'b0;
        chk("stop_done_req", 32'(sd_req), 0);
        chk("stop_done_busy", 32'(busy), 1);
        chk("stop_done_noflush", 32'(fifo_flush), 0);
        tick();
        chk("stop_flush", 32'(fifo_flush), 1);
        chk("stop_idle", 32'(busy), 0);
        chk("stop_level", 32'(dut.level), 0);
        repeat (10) tick();
        chk("stop_no_req", 32'(sd_req), 0);
        chk("stop_flush_end", 32'(fifo_flush), 0);

        // sd_err while a block is outstanding
        block_count = 16'd1; start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("err_pre_req", 32'(sd_req), 1);
        sd_err = 1'b1; sd_done = 1'b1; tick(); sd_err = 1'b0; sd_done = 1'b0;
        chk("sderr_err", 32'(err), 1);
        chk("sderr_req", 32'(sd_req), 0);
        chk("sderr_busy", 32'(busy), 0);

        // start leaves ERROR, then a read at level 0 faults
        start = 1'b1; tick(); start = 1'b0;
        chk("errstart_err", 32'(err), 0);
        chk("errstart_flush", 32'(fifo_flush), 1);
        tick();
        chk("errstart_req", 32'(sd_req), 1);
        fifo_r = 1'b1; tick(); fifo_r = 1'b0;
        chk("udf_err", 32'(err), 1);
        chk("udf_req", 32'(sd_req), 0);
        chk("udf_ready", 32'(spi_d_ready), 0);

        // asynchronous reset in the middle of an open chunk
        start = 1'b1; tick(); start = 1'b0;
        reset_model();
        run_model(2000, 1'b1, 1'b1, 3);
        chk("mid_chunk_reached", 32'(hit), 1);
        chk("mid_chunk_ready", 32'(spi_d_ready), 1);
        chk("mid_chunk_req", 32'(sd_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_sd_req", 32'(sd_req), 0);
        chk("arst_ready", 32'(spi_d_ready), 0);
        chk("arst_flush", 32'(fifo_flush), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_level", 32'(dut.level), 0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_flush", 32'(fifo_flush), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_readout_sched.md
# sd_readout_sched

Flow scheduler for the SD-readout-to-STM-SPI path in the ICE40 app. It issues one SD block read at a time into the readout FIFO, but only when the FIFO has room for a whole block. It tracks FIFO occupancy from write and read strobes, and drives `spi_d_ready` so the STM only starts a chunk read when a full chunk is buffered. It sits between the SPI command decoder (start/stop), the SD data-read engine, and the FIFO/SPI readout logic.

## Interface
Parameters:
- `FifoDepthWords`, 512: FIFO capacity in 16-bit words.
- `BlockWords`, 256: words per SD block (512 B).
- `ChunkWords`, 128: words per STM chunk read. `BlockWords` must be a multiple of `ChunkWords`, and `FifoDepthWords` must be ≥ `BlockWords`.

Ports:
- `clk` in 1: single clock; all logic in this domain.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; begins readout.
- `block_count` in 16: number of blocks to read, sampled on `start`. 0 = continuous until `stop`.
- `stop` in 1: one-cycle pulse; graceful abort.
- `sd_req` out 1: request one SD block read; level.
- `sd_done` in 1: one-cycle pulse; the block is fully written to the FIFO.
- `sd_err` in 1: one-cycle pulse; the block failed (CRC or timeout).
- `fifo_w` in 1: one word written to the FIFO this cycle.
- `fifo_r` in 1: one word read from the FIFO this cycle.
- `fifo_flush` out 1: one-cycle pulse; the FIFO must clear.
- `spi_d_ready` out 1: a full chunk is available to the STM.
- `busy` out 1: high in any state other than IDLE and ERROR.
- `err` out 1: sticky error flag; cleared by the next accepted `start`.

## Operation
Reset value of every output: `sd_req`=0, `spi_d_ready`=0, `fifo_flush`=0, `busy`=0, `err`=0. After reset: state=IDLE, `level`=0, `remaining`=0.

State machine:
- IDLE
  - On `start`: `remaining` ← `block_count`; pulse `fifo_flush`; `level` ← 0; clear `err`; go to CHECK.
  - `stop` in IDLE is ignored.
- CHECK
  - `stop` seen → DRAIN.
  - `remaining`==0 in finite mode → DRAIN.
  - `FifoDepthWords − level ≥ BlockWords` → REQ.
  - Otherwise stay in CHECK.
- REQ
  - `sd_req`=1, held until `sd_done` or `sd_err`. Exactly one block is ever outstanding.
  - On `sd_done`: decrement `remaining` (finite mode only), then CHECK.
  - On `sd_err`: go to ERROR.
  - A `stop` seen in REQ is latched. REQ still waits for `sd_done`, because an SD block cannot be cut short, then goes to DRAIN.
- DRAIN
  - Wait for `level`==0 with no chunk in progress, then IDLE.
  - A `stop` while in DRAIN, or a latched `stop`, skips the wait: pulse `fifo_flush` and go to IDLE.
- ERROR
  - `err`=1, `sd_req`=0, `spi_d_ready`=0.
  - `start` leaves ERROR exactly as it leaves IDLE.

Occupancy counter `level` (width `$clog2(FifoDepthWords+1)`):
- `fifo_w` alone: +1. `fifo_r` alone: −1. Both in the same cycle: unchanged.
- `fifo_w` while `level`==`FifoDepthWords` (overflow) → ERROR.
- `fifo_r` while `level`==0 (underflow) → ERROR.
- `fifo_r` while no chunk is open → ERROR.

Chunk logic:
- Opening a chunk: `spi_d_ready` rises when `level ≥ ChunkWords`, no chunk is open, and the mandatory low cycle has been served. This opens a chunk and clears `chunk_cnt`.
- Each `fifo_r` increments `chunk_cnt`.
- On the `ChunkWords`-th read, `spi_d_ready` falls on the next edge and the chunk closes.
- `spi_d_ready` must then stay low for at least 1 cycle before rising again, so the STM always sees an edge.
- `stop`/flush with a chunk open: the chunk closes and `spi_d_ready` falls.

## Timing
- `start` → `sd_req`=1 on edge 2 (one cycle in CHECK), given room in the FIFO.
- `sd_done` → `sd_req`=0 on the next edge; the next `sd_req` is asserted 2 edges after that at the earliest.
- `fifo_w` that makes `level`=`ChunkWords` → `spi_d_ready`=1 one edge later. The output is registered.
- Last chunk read → `spi_d_ready`=0 one edge later; earliest re-assert is 2 edges after the last read.
- `sd_done` and `stop` in the same cycle: the block is counted, then DRAIN.
- `sd_err` and `sd_done` in the same cycle: `sd_err` wins.
- `rst` mid-operation: all outputs go to their reset values immediately (asynchronous). No `fifo_flush` pulse is generated.

## Structure
- Package `readout_pkg`:
  - state enum `readout_state_t` (IDLE, CHECK, REQ, DRAIN, ERROR);
  - default parameter constants;
  - `level` width function.
- Sub-module `readout_level`: occupancy up/down counter with overflow and underflow flags.
- The FSM and chunk logic stay in `sd_readout_sched`.

## Test plan
- Finite run:
  - Stimulus: `block_count`=2; the bench model writes 256 words per `sd_req` and the STM reads 128-word chunks on `spi_d_ready`.
  - Required: exactly 2 `sd_req` handshakes, 4 `spi_d_ready` pulses, final `level`=0, `busy`=0, `err`=0.
- Backpressure:
  - Stimulus: the STM never reads.
  - Required: exactly 2 blocks requested (`level`=512), `sd_req` stays 0 thereafter. After 256 reads, the third `sd_req` is asserted.
- Stop mid-block:
  - Stimulus: `stop` pulsed during REQ.
  - Required: `sd_req` held until `sd_done`, then `fifo_flush` pulse, IDLE, no further `sd_req`.
- Errors:
  - `sd_err` → ERROR, `err`=1, `sd_req`=0.
  - `fifo_r` at `level`=0 → `err`=1.
  - A `fifo_w`/`fifo_r` pair in the same cycle at `level`=512 → no error, `level` stays 512.
- Chunk edge:
  - Stimulus: `level` ≥ 256 and back-to-back chunk reads.
  - Required: `spi_d_ready` low for ≥1 cycle between chunks.
- Reset:
  - Stimulus: `rst` asserted mid-chunk.
  - Required: all outputs 0 immediately, `level`=0.
